display_scan_ctrl: RTL

- Drives a multiplexed common-anode 7-segment bank of DIGITS digits from one binary value (e.g. free parking places).
- Converts the captured value to BCD with a sequential shift-add-3 FSM (double dabble).
- Time-shares a single 4-bit-to-7-segment transcoder: emits one 4-bit digit code plus an active-low anode select per scan slot.
- Sits between the occupancy counter logic and the shared transcoder instance.

---
 rtl/display_scan_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: sequential binary-to-BCD conversion
// (double dabble) feeding a time-shared digit-code / anode-select output.
//
// state  | meaning
// IDLE   | waiting for load; display register holds last committed value
// SHIFT  | VAL_W shift-add-3 iterations on {bcd, bin}
// COMMIT | copy finished BCD to display register, drop busy
module display_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    input  logic              full_flag,
    input  logic              lz_blank,
    output logic [3:0]        digit_code,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VAL_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int XW = (VAL_W > 32) ? VAL_W : 32;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAXV = pow10(DIGITS) - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [VAL_W-1:0] bin, bin_nxt;
    logic [BW-1:0]   bcd, bcd_nxt, adj;
    logic [BW-1:0]   disp, disp_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [PW-1:0]   pre;
    logic [IW-1:0]   idx;
    logic [XW-1:0]   value_x;
    logic            sat;
    logic            upper_zero;
    logic [3:0]      sel, code_nxt;
    logic [DIGITS-1:0] an_nxt;

    assign value_x = XW'(value);
    assign sat     = value_x > XW'(MAXV);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin;
        bcd_nxt   = bcd;
        cnt_nxt   = cnt;
        disp_nxt  = disp;
        adj       = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nxt   = sat ? VAL_W'(MAXV) : value;
                    bcd_nxt   = '0;
                    cnt_nxt   = CW'(VAL_W - 1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt = {adj[BW-2:0], bin[VAL_W-1]};
                bin_nxt = bin << 1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == '0) state_nxt = COMMIT;
            end
            COMMIT: begin
                disp_nxt  = bcd;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Blanking looks at the selected digit and everything more significant.
    always_comb begin
        upper_zero = 1'b1;
        sel        = 4'd0;
        an_nxt     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx && disp[4*i +: 4] != 4'd0) upper_zero = 1'b0;
            if (IW'(i) == idx) begin
                sel       = disp[4*i +: 4];
                an_nxt[i] = 1'b0;
            end
        end
        if (full_flag)                                  code_nxt = 4'd10;
        else if (lz_blank && idx != '0 && upper_zero)   code_nxt = 4'd15;
        else                                            code_nxt = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            disp       <= '0;
            pre        <= '0;
            idx        <= '0;
            an         <= '1;
            digit_code <= 4'd15;
        end else begin
            bin        <= bin_nxt;
            bcd        <= bcd_nxt;
            cnt        <= cnt_nxt;
            disp       <= disp_nxt;
            an         <= an_nxt;
            digit_code <= code_nxt;
            if (pre == PW'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule
